cpu_io_bridge: RTL and testbench
================================

CPU_IO_BRIDGE -- requirements
Module: cpu_io_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per FIFO; power of two, >= 2.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, meaning cycles to wait for cpu_in_rd before retrying; range 1..255.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port host_in_data  in  8  byte from host to CPU.
REQ-006 SHALL have port host_in_valid  in  1  host_in_data is valid.
REQ-007 SHALL have port host_in_ready  out  1  inbound FIFO is not full.
REQ-008 SHALL have port host_out_data  out  8  head of the outbound FIFO.
REQ-009 SHALL have port host_out_valid  out  1  outbound FIFO is not empty.
REQ-010 SHALL have port host_out_ready  in  1  host accepts host_out_data.
REQ-011 SHALL have port cpu_in_port  out  8  drives the processor In_port.
REQ-012 SHALL have port cpu_int  out  1  drives the processor int input.
REQ-013 SHALL have port cpu_in_rd  in  1  pulse: the CPU has consumed cpu_in_port (IN instruction reached write-back).
REQ-014 SHALL have port cpu_out_port  in  8  processor Out_port.
REQ-015 SHALL have port cpu_out_wr  in  1  pulse: Out_port was loaded this cycle (out_ld at write-back).
REQ-016 SHALL have port cpu_hlt  in  1  processor HLT flag.
REQ-017 SHALL have port ovf  out  1  sticky flag: an outbound byte was dropped.

Function
REQ-018 Inbound FIFO SHALL push host_in_data on any cycle where host_in_valid && host_in_ready; host_in_ready = (count < DEPTH).
REQ-019 Outbound FIFO SHALL push cpu_out_port on cpu_out_wr when not full; if full, the byte SHALL be dropped and ovf set until rst.
REQ-020 Outbound FIFO SHALL pop on host_out_valid && host_out_ready; host_out_data SHALL equal the head entry combinationally.
REQ-021 Simultaneous push and pop on either FIFO SHALL leave count unchanged and be accepted even when full (outbound) or empty is not involved; a push into an empty FIFO SHALL be visible at the head on the next cycle.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-023 Delivery FSM SHALL have the states IDLE, PULSE and WAIT_ACK.
REQ-024 IDLE -> PULSE SHALL occur when the inbound FIFO is not empty and cpu_hlt=0; on that edge cpu_in_port SHALL latch the FIFO head.
REQ-025 In PULSE, cpu_int SHALL be 1 for exactly one cycle, and the FSM SHALL then move to WAIT_ACK.
REQ-026 In WAIT_ACK, cpu_in_rd=1 SHALL pop the inbound FIFO and return the FSM to IDLE; cpu_in_port SHALL hold its value until the next latch.
REQ-027 cpu_in_rd SHALL be ignored in IDLE and PULSE.
REQ-028 cpu_hlt=1 SHALL block IDLE -> PULSE only; an in-flight delivery SHALL complete normally.
REQ-029 Minimum spacing between consecutive cpu_int pulses SHALL be 3 cycles (IDLE, PULSE, WAIT_ACK with an immediate ack).

Reset
REQ-030 On rst, both FIFOs SHALL become empty, the FSM SHALL enter IDLE, the timeout counter SHALL clear, and the outputs SHALL be cpu_in_port=0, cpu_int=0, ovf=0, host_out_valid=0, host_in_ready=1.
REQ-031 rst asserted in any state SHALL take priority over every other event in that cycle; bytes in flight SHALL be discarded.

Configuration
REQ-032 Macro IO_BRIDGE_TIMEOUT_EN defined: in WAIT_ACK an 8-bit counter SHALL count cycles, and on reaching ACK_TIMEOUT without cpu_in_rd the FSM SHALL return to PULSE (re-pulse cpu_int, same byte, counter cleared).
REQ-033 Macro IO_BRIDGE_TIMEOUT_EN undefined: the FSM SHALL stay in WAIT_ACK indefinitely, and no counter SHALL be synthesised.

Verification
REQ-034 Reset, push host bytes 0xA5 then 0x3C, then ack each 2 cycles after its cpu_int -> one cpu_int pulse per byte; cpu_in_port = 0xA5 then 0x3C; FIFO empty at end.
REQ-035 Push 5 bytes with DEPTH=4 and no ack -> host_in_ready=0 after the 4th push; the 5th byte is not accepted until the first ack.
REQ-036 Pulse cpu_out_wr 5 times (0x01..0x05) with host_out_ready=0 -> ovf=1; draining yields 0x01..0x04.
REQ-037 Assert cpu_hlt=1 with 1 byte queued in IDLE -> no cpu_int while HLT is high; cpu_int is pulsed 1 cycle after cpu_hlt falls.
REQ-038 With IO_BRIDGE_TIMEOUT_EN and ACK_TIMEOUT=15, withhold the ack -> cpu_int re-pulses 17 cycles after the first pulse with the same cpu_in_port; without the macro -> a single pulse only.
REQ-039 Assert rst in WAIT_ACK with 3 bytes queued -> next cycle cpu_int=0, cpu_in_port=0, host_in_ready=1, and no further cpu_int.

Source files
------------

// File: rtl/cpu_io_bridge.sv
// Byte bridge between a host stream interface and a simple CPU's In/Out ports.
// Optional ack timeout/re-pulse enabled by defining IO_BRIDGE_TIMEOUT_EN.
module cpu_io_bridge #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] host_in_data,
  input  logic       host_in_valid,
  output logic       host_in_ready,
  output logic [7:0] host_out_data,
  output logic       host_out_valid,
  input  logic       host_out_ready,
  output logic [7:0] cpu_in_port,
  output logic       cpu_int,
  input  logic       cpu_in_rd,
  input  logic [7:0] cpu_out_port,
  input  logic       cpu_out_wr,
  input  logic       cpu_hlt,
  output logic       ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cpu_io_bridge: DEPTH must be a power of two >= 2");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
    $error("cpu_io_bridge: ACK_TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StPulse, StWaitAck} state_e;
  state_e state_q;

  // Inbound FIFO: host -> CPU. The head stays queued until the CPU acks it.
  logic [7:0]    in_mem [DEPTH];
  logic [AW-1:0] in_wr_ptr_q, in_rd_ptr_q;
  logic [AW:0]   in_cnt_q;
  logic          in_push, in_pop;

  assign host_in_ready = (in_cnt_q < FullCnt);
  assign in_push       = host_in_valid && host_in_ready;
  assign in_pop        = (state_q == StWaitAck) && cpu_in_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_wr_ptr_q <= '0;
      in_rd_ptr_q <= '0;
      in_cnt_q    <= '0;
    end else begin
      if (in_push) begin
        in_mem[in_wr_ptr_q] <= host_in_data;
        in_wr_ptr_q         <= in_wr_ptr_q + 1'b1;
      end
      if (in_pop) in_rd_ptr_q <= in_rd_ptr_q + 1'b1;
      case ({in_push, in_pop})
        2'b10:   in_cnt_q <= in_cnt_q + 1'b1;
        2'b01:   in_cnt_q <= in_cnt_q - 1'b1;
        default: in_cnt_q <= in_cnt_q;
      endcase
    end
  end

  // Outbound FIFO: CPU -> host. A write while full survives only if the host pops that cycle.
  logic [7:0]    out_mem [DEPTH];
  logic [AW-1:0] out_wr_ptr_q, out_rd_ptr_q;
  logic [AW:0]   out_cnt_q;
  logic          out_push, out_pop, out_full;

  assign out_full       = (out_cnt_q == FullCnt);
  assign host_out_valid = (out_cnt_q != '0);
  assign host_out_data  = out_mem[out_rd_ptr_q];
  assign out_pop        = host_out_valid && host_out_ready;
  assign out_push       = cpu_out_wr && (!out_full || out_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_wr_ptr_q <= '0;
      out_rd_ptr_q <= '0;
      out_cnt_q    <= '0;
      ovf          <= 1'b0;
    end else begin
      if (out_push) begin
        out_mem[out_wr_ptr_q] <= cpu_out_port;
        out_wr_ptr_q          <= out_wr_ptr_q + 1'b1;
      end
      if (out_pop) out_rd_ptr_q <= out_rd_ptr_q + 1'b1;
      if (cpu_out_wr && !out_push) ovf <= 1'b1;
      case ({out_push, out_pop})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

`ifdef IO_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] AckTimeout = 8'(ACK_TIMEOUT);
  logic [7:0] ack_cnt_q;
`endif

  // Delivery FSM; cpu_int is high exactly while in StPulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cpu_int     <= 1'b0;
      cpu_in_port <= 8'h00;
`ifdef IO_BRIDGE_TIMEOUT_EN
      ack_cnt_q   <= 8'h00;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_cnt_q != '0 && !cpu_hlt) begin
            state_q     <= StPulse;
            cpu_int     <= 1'b1;
            cpu_in_port <= in_mem[in_rd_ptr_q];
          end
        end
        StPulse: begin
          state_q <= StWaitAck;
          cpu_int <= 1'b0;
`ifdef IO_BRIDGE_TIMEOUT_EN
          ack_cnt_q <= 8'h00;
`endif
        end
        StWaitAck: begin
          if (cpu_in_rd) begin
            state_q <= StIdle;
`ifdef IO_BRIDGE_TIMEOUT_EN
            ack_cnt_q <= 8'h00;
          end else if (ack_cnt_q == AckTimeout) begin
            state_q   <= StPulse;
            cpu_int   <= 1'b1;
            ack_cnt_q <= 8'h00;
          end else begin
            ack_cnt_q <= ack_cnt_q + 8'd1;
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          cpu_int <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Self-checking bench for cpu_io_bridge: directed scenarios, then randomized traffic
// checked against a queue-based reference model.
module tb_cpu_io_bridge;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] host_in_data;
  logic       host_in_valid;
  logic       host_in_ready;
  logic [7:0] host_out_data;
  logic       host_out_valid;
  logic       host_out_ready;
  logic [7:0] cpu_in_port;
  logic       cpu_int;
  logic       cpu_in_rd;
  logic [7:0] cpu_out_port;
  logic       cpu_out_wr;
  logic       cpu_hlt;
  logic       ovf;

  int checks = 0;
  int failures = 0;
  int int_pulses = 0;
  int int_long = 0;
  logic int_prev = 1'b0;

  cpu_io_bridge #(.DEPTH(DEPTH), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready),
    .cpu_in_port(cpu_in_port), .cpu_int(cpu_int), .cpu_in_rd(cpu_in_rd),
    .cpu_out_port(cpu_out_port), .cpu_out_wr(cpu_out_wr), .cpu_hlt(cpu_hlt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    int_prev <= cpu_int;
    if (cpu_int === 1'b1) int_pulses <= int_pulses + 1;
    if (cpu_int === 1'b1 && int_prev === 1'b1) int_long <= int_long + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_int(input int max, output bit seen, output int w);
    seen = 1'b0;
    w = 0;
    while (!seen && w <= max) begin
      if (cpu_int === 1'b1) seen = 1'b1;
      else begin
        tick();
        w++;
      end
    end
  endtask

  // Wait for a pulse, check its byte and width, then ack 'delay' cycles after the pulse.
  task automatic deliver(input string tag, input logic [7:0] exp, input int delay,
                         input int exp_wait);
    bit seen;
    int w;
    wait_int(50, seen, w);
    chk({tag, "_int"}, 32'(seen), 1);
    if (exp_wait >= 0) chk({tag, "_gap"}, 32'(w), 32'(exp_wait));
    chk({tag, "_port"}, 32'(cpu_in_port), 32'(exp));
    tick();
    chk({tag, "_one"}, 32'(cpu_int), 0);
    repeat (delay - 1) tick();
    cpu_in_rd = 1'b1;
    tick();
    cpu_in_rd = 1'b0;
    chk({tag, "_hold"}, 32'(cpu_in_port), 32'(exp));
  endtask

  int p0;
  bit seen0;
  int w0;
  int phase;
  int wait_cnt;
  logic [7:0] exp_port;
  logic exp_ovf;
  logic r_v, r_rd, r_hlt, r_ow, r_ordy, in_full, out_full, out_pop;
  logic [7:0] r_d, r_od;
  byte unsigned in_q[$];
  byte unsigned out_q[$];

  initial begin
    host_in_data = 8'h00; host_in_valid = 1'b0; host_out_ready = 1'b0;
    cpu_in_rd = 1'b0; cpu_out_port = 8'h00; cpu_out_wr = 1'b0; cpu_hlt = 1'b0;

    // Reset state
    do_reset();
    chk("rst_int", 32'(cpu_int), 0);
    chk("rst_port", 32'(cpu_in_port), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_ovalid", 32'(host_out_valid), 0);
    chk("rst_iready", 32'(host_in_ready), 1);

    // Two bytes, each acked 2 cycles after its pulse
    p0 = int_pulses;
    host_in_valid = 1'b1; host_in_data = 8'hA5;
    tick();
    host_in_data = 8'h3C;
    tick();
    host_in_valid = 1'b0;
    deliver("b1", 8'hA5, 2, 0);
    deliver("b2", 8'h3C, 2, 1);
    repeat (10) tick();
    chk("two_pulses", 32'(int_pulses - p0), 2);
    chk("two_empty", 32'(host_in_ready), 1);

    // Inbound back-pressure with no ack
    do_reset();
    host_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      host_in_data = 8'(i * 8'h11);
      tick();
    end
    chk("full_ready", 32'(host_in_ready), 0);
    host_in_data = 8'h55;
    repeat (3) tick();
    chk("full_hold", 32'(host_in_ready), 0);
    chk("full_port", 32'(cpu_in_port), 32'h11);
    cpu_in_rd = 1'b1;
    tick();
    cpu_in_rd = 1'b0;
    chk("ack_ready", 32'(host_in_ready), 1);
    tick();
    host_in_valid = 1'b0;
    chk("refill_ready", 32'(host_in_ready), 0);
    deliver("d2", 8'h22, 1, 0);
    deliver("d3", 8'h33, 1, 1);
    deliver("d4", 8'h44, 1, 1);
    deliver("d5", 8'h55, 1, 1);

    // Outbound overflow, then drain
    do_reset();
    cpu_out_wr = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cpu_out_port = 8'(i);
      tick();
      if (i == 4) chk("ovf_before", 32'(ovf), 0);
    end
    cpu_out_wr = 1'b0;
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_valid", 32'(host_out_valid), 1);
    host_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 32'(host_out_data), 32'(i));
      tick();
    end
    host_out_ready = 1'b0;
    chk("drain_empty", 32'(host_out_valid), 0);
    chk("ovf_sticky", 32'(ovf), 1);

    // HLT blocks new deliveries
    do_reset();
    chk("ovf_cleared", 32'(ovf), 0);
    cpu_hlt = 1'b1;
    p0 = int_pulses;
    host_in_valid = 1'b1; host_in_data = 8'h77;
    tick();
    host_in_valid = 1'b0;
    repeat (6) tick();
    chk("hlt_noint", 32'(int_pulses - p0), 0);
    cpu_hlt = 1'b0;
    tick();
    chk("hlt_release", 32'(cpu_int), 1);
    chk("hlt_port", 32'(cpu_in_port), 32'h77);
    tick();
    cpu_in_rd = 1'b1;
    tick();
    cpu_in_rd = 1'b0;

    // Withheld ack
    host_in_valid = 1'b1; host_in_data = 8'h9A;
    tick();
    host_in_valid = 1'b0;
    wait_int(10, seen0, w0);
    chk("to_first", 32'(seen0), 1);
    p0 = int_pulses;
`ifdef IO_BRIDGE_TIMEOUT_EN
    repeat (16) tick();
    chk("to_quiet", 32'(cpu_int), 0);
    tick();
    chk("to_repulse", 32'(cpu_int), 1);
    chk("to_port", 32'(cpu_in_port), 32'h9A);
    tick();
`else
    repeat (40) tick();
    chk("to_single", 32'(int_pulses - p0), 1);
    chk("to_port", 32'(cpu_in_port), 32'h9A);
`endif

    // Reset while waiting for an ack with three bytes queued
    host_in_valid = 1'b1;
    host_in_data = 8'hB1;
    tick();
    host_in_data = 8'hB2;
    tick();
    host_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrst_int", 32'(cpu_int), 0);
    chk("wrst_port", 32'(cpu_in_port), 0);
    chk("wrst_ready", 32'(host_in_ready), 1);
    p0 = int_pulses;
    repeat (20) tick();
    chk("wrst_noint", 32'(int_pulses - p0), 0);

    // Randomized traffic against a queue model
    do_reset();
    phase = 0; wait_cnt = 0; exp_port = 8'h00; exp_ovf = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      r_v = 1'($urandom_range(0, 1));
      r_d = 8'($urandom);
      r_rd = ($urandom_range(0, 2) == 0);
      r_hlt = ($urandom_range(0, 5) == 0);
      r_ow = ($urandom_range(0, 2) == 0);
      r_od = 8'($urandom);
      r_ordy = ($urandom_range(0, 3) == 0);
      if (phase == 2 && wait_cnt >= 10) r_rd = 1'b1;
      host_in_valid = r_v; host_in_data = r_d; cpu_in_rd = r_rd; cpu_hlt = r_hlt;
      cpu_out_wr = r_ow; cpu_out_port = r_od; host_out_ready = r_ordy;

      chk("rnd_iready", 32'(host_in_ready), 32'(in_q.size() < DEPTH));
      chk("rnd_ovalid", 32'(host_out_valid), 32'(out_q.size() != 0));
      if (out_q.size() != 0) chk("rnd_odata", 32'(host_out_data), 32'(out_q[0]));

      in_full = (in_q.size() >= DEPTH);
      out_full = (out_q.size() == DEPTH);
      out_pop = r_ordy && (out_q.size() != 0);
      case (phase)
        0: if (in_q.size() != 0 && !r_hlt) begin
             phase = 1;
             exp_port = in_q[0];
           end
        1: begin
             phase = 2;
             wait_cnt = 0;
           end
        default: if (r_rd) begin
                   phase = 0;
                   void'(in_q.pop_front());
                 end else wait_cnt++;
      endcase
      if (r_v && !in_full) in_q.push_back(r_d);
      if (out_pop) void'(out_q.pop_front());
      if (r_ow) begin
        if (!out_full || out_pop) out_q.push_back(r_od);
        else exp_ovf = 1'b1;
      end

      tick();
      chk("rnd_int", 32'(cpu_int), 32'(phase == 1));
      chk("rnd_port", 32'(cpu_in_port), 32'(exp_port));
      chk("rnd_ovf", 32'(ovf), 32'(exp_ovf));
    end
    host_in_valid = 1'b0; cpu_in_rd = 1'b0; cpu_hlt = 1'b0; cpu_out_wr = 1'b0;
    host_out_ready = 1'b0;
    tick();
    chk("int_width", 32'(int_long), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
